// File: rtl/mxu_operand_loader_pkg.sv
//------------------------------------------------------------------------------
// mxu_operand_loader_pkg : shared types for the MXU operand loader
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mxu_operand_loader_pkg;

    localparam int MXU_DIM      = 4;
    localparam int MXU_BITWIDTH = 8;

    typedef logic [MXU_DIM-1:0][MXU_DIM-1:0][MXU_BITWIDTH-1:0] matrix_t;

    // Bit 1 = fill set holds a complete pair, bit 0 = multiplier is computing
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_READY   = 2'b10,
        ST_STALL   = 2'b11
    } ld_state_e;

    function automatic logic st_fill_full(input ld_state_e s);
        return s[1];
    endfunction

    function automatic logic st_in_flight(input ld_state_e s);
        return s[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mxu_operand_loader.sv
//------------------------------------------------------------------------------
// mxu_operand_loader : assembles A/B operand matrices from a serial stream and
//                      launches them into the matrix multiplier (double buffered)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mxu_operand_loader
    import mxu_operand_loader_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_last,
    output logic [DIM*DIM*WIDTH-1:0]   in0,
    output logic [DIM*DIM*WIDTH-1:0]   in1,
    output logic                       in_valid,
    input  logic                       mxu_finished,
    output logic                       busy,
    output logic [15:0]                launch_count,
    output logic                       err_framing,
    output logic                       err_spurious
);

    localparam int c_NUM    = DIM * DIM;
    localparam int c_TOTAL  = 2 * c_NUM;
    localparam int c_CNT_W  = $clog2(c_TOTAL);
    localparam int c_ELEM_W = (c_NUM > 1) ? $clog2(c_NUM) : 1;
    localparam int c_MAT_W  = c_NUM * WIDTH;

    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_TOTAL - 1);
    localparam logic [c_CNT_W-1:0] c_B_BASE   = c_CNT_W'(c_NUM);

    ld_state_e              r_state;
    ld_state_e              w_state_nxt;
    logic [c_CNT_W-1:0]     r_fill_cnt;
    logic [c_MAT_W-1:0]     r_fill_a;
    logic [c_MAT_W-1:0]     r_fill_b;
    logic [c_MAT_W-1:0]     r_in0;
    logic [c_MAT_W-1:0]     r_in1;
    logic                   r_in_valid;
    logic [15:0]            r_launch_count;
    logic                   r_err_framing;
    logic                   r_err_spurious;

    logic                   w_fill_full;
    logic                   w_in_flight;
    logic                   w_accept;
    logic                   w_at_last;
    logic                   w_is_b;
    logic                   w_launch;
    logic [c_ELEM_W-1:0]    w_elem;

    assign w_fill_full = st_fill_full(r_state);
    assign w_in_flight = st_in_flight(r_state);
    assign s_ready     = reset_n && !w_fill_full;
    assign w_accept    = s_valid && s_ready;
    assign w_at_last   = (r_fill_cnt == c_LAST_IDX);
    assign w_is_b      = (r_fill_cnt >= c_B_BASE);
    // Row-major flat index equals the in-matrix element number, so no divide is needed
    assign w_elem      = c_ELEM_W'(w_is_b ? (r_fill_cnt - c_B_BASE) : r_fill_cnt);
    assign w_launch    = w_fill_full && (!w_in_flight || mxu_finished);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_launch) begin
            w_state_nxt = ST_COMPUTE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_at_last) w_state_nxt = ST_READY;
                end
                ST_COMPUTE: begin
                    if (w_accept && w_at_last) begin
                        w_state_nxt = mxu_finished ? ST_READY : ST_STALL;
                    end else if (mxu_finished) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_READY:  w_state_nxt = ST_READY;
                ST_STALL:  w_state_nxt = ST_STALL;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill_cnt     <= '0;
            r_fill_a       <= '0;
            r_fill_b       <= '0;
            r_in0          <= '0;
            r_in1          <= '0;
            r_in_valid     <= 1'b0;
            r_launch_count <= 16'd0;
            r_err_framing  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_in_valid <= w_launch;
            if (w_accept) begin
                if (w_is_b) begin
                    r_fill_b[w_elem*WIDTH +: WIDTH] <= s_data;
                end else begin
                    r_fill_a[w_elem*WIDTH +: WIDTH] <= s_data;
                end
                r_fill_cnt <= w_at_last ? '0 : r_fill_cnt + 1'b1;
                // Framing errors are only flagged; storage keeps following the counter
                if (s_last != w_at_last) begin
                    r_err_framing <= 1'b1;
                end
            end
            if (w_launch) begin
                r_in0          <= r_fill_a;
                r_in1          <= r_fill_b;
                r_launch_count <= r_launch_count + 16'd1;
            end
            if (mxu_finished && !w_in_flight) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign in0          = r_in0;
    assign in1          = r_in1;
    assign in_valid     = r_in_valid;
    assign launch_count = r_launch_count;
    assign err_framing  = r_err_framing;
    assign err_spurious = r_err_spurious;
    assign busy         = (r_fill_cnt != '0) || w_fill_full || w_in_flight;

endmodule

`default_nettype wire
